pic_priority_sequencer: RTL
===========================

Name: pic_priority_sequencer

Overview:
- Parametrised successor to the 8259A-style control logic.
- Resolves NUM_IRQ request lines through IRR/IMR/ISR with fixed or rotating priority and fully nested masking.
- Raises an interrupt to the CPU and runs the two-pulse INTA acknowledge sequence, then drives the vector onto the data path.
- Sits between the interrupt request register inputs and the data bus buffer; handles EOI/rotation commands decoded from OCW2.

Parameters:
- NUM_IRQ, 8, number of request channels; legal range 2..32.
- IDX_W, 3, channel index width; must equal clog2(NUM_IRQ).
- VEC_W, 8, vector width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq  in  NUM_IRQ  request lines, synchronous to clk.
- level_mode  in  1  1 = level-triggered IRR, 0 = edge-triggered.
- mask_we  in  1  one-cycle write strobe for IMR.
- mask_wdata  in  NUM_IRQ  new IMR value.
- vector_base  in  VEC_W  vector base from ICW2.
- eoi_valid  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific.
- eoi_level  in  IDX_W  channel for specific EOI.
- rotate_on_eoi  in  1  rotate priority on this EOI.
- inta_n  in  1  acknowledge pulses, active low, synchronous to clk.
- int_out  out  1  interrupt request to CPU.
- vector_out  out  VEC_W  vector presented during second INTA.
- vector_oe  out  1  vector_out valid / bus-buffer drive enable.
- irr  out  NUM_IRQ  interrupt request register.
- imr  out  NUM_IRQ  interrupt mask register.
- isr  out  NUM_IRQ  in-service register.

Behaviour:

Reset values:
- irr, isr, vector_out = 0.
- imr = all ones.
- int_out = 0, vector_oe = 0.
- lowest_prio pointer = NUM_IRQ-1, so IR0 has highest priority.
- FSM = IDLE.
- irq_q and inta_q history registers = 0 and 1 respectively.

IRR capture:
- Level mode: irr = irq, registered.
- Edge mode: a bit is set on a registered 0->1 edge of irq. It is cleared when irq falls or when the bit is latched into ISR.

Priority:
- The priority order starts at (lowest_prio+1) mod NUM_IRQ and wraps.
- pending = irr & ~imr.
- The candidate is the highest-priority pending bit, and only if that bit is strictly higher priority than every set ISR bit (fully nested).

FSM (state IDLE, ARMED, ACK1, ACK2):
- IDLE -> ARMED when a candidate exists. int_out is registered high on entry to ARMED (1-cycle latency from irr).
- ARMED -> IDLE if the candidate vanishes (masked, irq withdrawn); int_out drops the next cycle.
- ARMED -> ACK1 on an inta_n falling edge (inta_q=1, inta_n=0). In that cycle:
  - Freeze: latch the candidate index.
  - Set its ISR bit and clear its IRR bit (edge mode).
  - int_out = 0.
- If no candidate exists at the ACK1 edge (spurious): no ISR change; latched index = NUM_IRQ-1.
- ACK1 -> ACK2 on the second inta_n falling edge:
  - vector_out = vector_base + index, truncated to VEC_W (wraps).
  - vector_oe = 1 while inta_n stays low.
- ACK2 -> IDLE on inta_n rising edge; vector_oe = 0.
- INTA edges in IDLE are ignored.

EOI:
- Non-specific: clears the highest-priority set ISR bit.
- Specific: clears isr[eoi_level]; eoi_level >= NUM_IRQ is ignored.
- If rotate_on_eoi, lowest_prio = the cleared index.
- An EOI with ISR empty is a no-op, including rotation.

Simultaneous events:
- EOI in the same cycle as ACK1: the EOI acts on the pre-existing ISR, then the new ISR bit is set. A non-specific EOI never clears the bit being set that cycle.
- mask_we in the same cycle as an ACK1 edge: the old IMR is used for the freeze.

Mid-operation reset: asynchronous return to reset values from any state. vector_oe drops immediately.

Optional Feature:
- Macro AUTO_EOI_EN.
- Defined:
  - Adds input port auto_eoi (1 bit).
  - When auto_eoi=1, the ISR bit set at ACK1 is cleared on the inta_n rising edge ending ACK2.
  - If rotate_on_eoi=1 at that edge, lowest_prio = that index.
- Undefined:
  - The port is absent.
  - ISR bits clear only via eoi_valid.

Test Plan:
1. Reset with NUM_IRQ=8, vector_base=8'h20; imr=0; irq[3] rises -> irr=8'h08, int_out=1 one cycle later; two INTA pulses -> isr=8'h08, irr=0, vector_out=8'h23 with vector_oe=1 during the second pulse.
2. irq[5] and irq[2] asserted together -> vector 8'h22 first; while isr=8'h04, irq[5] produces no int_out; non-specific EOI clears isr, then IR5 is served with vector 8'h25.
3. Rotation: serve IR4, then non-specific EOI with rotate_on_eoi=1 -> lowest_prio=4; assert irq[3] and irq[6] together -> IR6 served first (vector 8'h26).
4. Spurious: int_out raised by IR1, then irq[1] drops before the first INTA -> FSM returns to IDLE; a forced INTA pair in ARMED after the mask write imr=8'h02 -> vector 8'h27, isr unchanged.
5. Edge vs level: level_mode=0 with irq[0] held high after service and EOI -> no re-request. level_mode=1 under the same stimulus -> int_out reasserts.
6. Reset asserted during ACK2 with vector_oe=1 -> vector_oe=0, isr=0, imr=8'hFF immediately. With AUTO_EOI_EN and auto_eoi=1, a served IR2 leaves isr=0 after the second pulse.

Source files
------------

// File: rtl/pic_priority_sequencer.sv
// 8259A-style IRR/IMR/ISR priority resolver with two-pulse INTA sequencing and EOI/rotation.
// Optional macro AUTO_EOI_EN adds the auto_eoi input (ISR bit retired at the end of INTA).
module pic_priority_sequencer #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3,
  parameter int VEC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               level_mode,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic [VEC_W-1:0]   vector_base,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [IDX_W-1:0]   eoi_level,
  input  logic               rotate_on_eoi,
  input  logic               inta_n,
`ifdef AUTO_EOI_EN
  input  logic               auto_eoi,
`endif
  output logic               int_out,
  output logic [VEC_W-1:0]   vector_out,
  output logic               vector_oe,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] imr,
  output logic [NUM_IRQ-1:0] isr
);

  typedef enum logic [1:0] {IDLE, ARMED, ACK1, ACK2} state_t;

  state_t               state_q, state_d;
  logic [NUM_IRQ-1:0]   irq_q, irr_q, irr_d, imr_q, imr_d, isr_q, isr_d;
  logic                 inta_q;
  logic [IDX_W-1:0]     lp_q, lp_d, idx_q, idx_d;
  logic                 int_out_q, int_out_d, vec_oe_q, vec_oe_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
`ifdef AUTO_EOI_EN
  logic                 ack_live_q, ack_live_d;
`endif

  logic [NUM_IRQ-1:0]   pending, pend_rot, isr_rot, ack_set, eoi_clr, auto_clr;
  logic [2*NUM_IRQ-1:0] pend_dbl, isr_dbl;
  logic [IDX_W:0]       lp_plus1, pend_rank, isr_rank;
  logic [IDX_W-1:0]     cand_idx, isr_top_idx;
  logic                 cand_valid, inta_fall, inta_rise;

  // Rank of the lowest set bit; NUM_IRQ when the vector is empty.
  function automatic logic [IDX_W:0] first_set(input logic [NUM_IRQ-1:0] v);
    logic [IDX_W:0] r;
    r = (IDX_W+1)'(NUM_IRQ);
    for (int k = NUM_IRQ-1; k >= 0; k--)
      if (v[k]) r = (IDX_W+1)'(k);
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] rank_to_idx(input logic [IDX_W:0] base,
                                                   input logic [IDX_W:0] rank);
    logic [IDX_W+1:0] s;
    s = {1'b0, base} + {1'b0, rank};
    if (s >= (IDX_W+2)'(NUM_IRQ)) s = s - (IDX_W+2)'(NUM_IRQ);
    return s[IDX_W-1:0];
  endfunction

  // Rotate so bit 0 of *_rot is the channel right after the lowest-priority pointer.
  assign pending     = irr_q & ~imr_q;
  assign lp_plus1    = {1'b0, lp_q} + (IDX_W+1)'(1);
  assign pend_dbl    = {pending, pending} >> lp_plus1;
  assign isr_dbl     = {isr_q, isr_q} >> lp_plus1;
  assign pend_rot    = pend_dbl[NUM_IRQ-1:0];
  assign isr_rot     = isr_dbl[NUM_IRQ-1:0];
  assign pend_rank   = first_set(pend_rot);
  assign isr_rank    = first_set(isr_rot);
  assign cand_valid  = pend_rank < isr_rank;
  assign cand_idx    = rank_to_idx(lp_plus1, pend_rank);
  assign isr_top_idx = rank_to_idx(lp_plus1, isr_rank);
  assign inta_fall   = inta_q & ~inta_n;
  assign inta_rise   = ~inta_q & inta_n;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irr
    assign irr_d[gi] = level_mode ? irq[gi]
                     : irq[gi] & (irr_q[gi] | ~irq_q[gi]) & ~ack_set[gi];
  end

  always_comb begin
    state_d   = state_q;
    int_out_d = int_out_q;
    vec_d     = vec_q;
    vec_oe_d  = vec_oe_q;
    idx_d     = idx_q;
    ack_set   = '0;
    auto_clr  = '0;
    eoi_clr   = '0;
    lp_d      = lp_q;
`ifdef AUTO_EOI_EN
    ack_live_d = ack_live_q;
`endif

    // EOI always acts on the ISR as it stood before this cycle's acknowledge.
    if (eoi_valid && |isr_q) begin
      if (eoi_specific) begin
        eoi_clr = NUM_IRQ'(1) << eoi_level;
        if (rotate_on_eoi && |eoi_clr) lp_d = eoi_level;
      end else begin
        eoi_clr = NUM_IRQ'(1) << isr_top_idx;
        if (rotate_on_eoi) lp_d = isr_top_idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (cand_valid) begin
          state_d   = ARMED;
          int_out_d = 1'b1;
        end
      end
      ARMED: begin
        if (inta_fall) begin
          state_d   = ACK1;
          int_out_d = 1'b0;
          if (cand_valid) begin
            idx_d   = cand_idx;
            ack_set = NUM_IRQ'(1) << cand_idx;
          end else begin
            idx_d   = IDX_W'(NUM_IRQ-1);
          end
`ifdef AUTO_EOI_EN
          ack_live_d = cand_valid;
`endif
        end else if (!cand_valid) begin
          state_d   = IDLE;
          int_out_d = 1'b0;
        end
      end
      ACK1: begin
        if (inta_fall) begin
          state_d  = ACK2;
          vec_d    = vector_base + VEC_W'(idx_q);
          vec_oe_d = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_d  = IDLE;
          vec_oe_d = 1'b0;
`ifdef AUTO_EOI_EN
          if (auto_eoi && ack_live_q) begin
            auto_clr = NUM_IRQ'(1) << idx_q;
            if (rotate_on_eoi) lp_d = idx_q;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    isr_d = (isr_q & ~eoi_clr & ~auto_clr) | ack_set;
    imr_d = mask_we ? mask_wdata : imr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      inta_q    <= 1'b1;
      irr_q     <= '0;
      imr_q     <= '1;
      isr_q     <= '0;
      lp_q      <= IDX_W'(NUM_IRQ-1);
      idx_q     <= '0;
      int_out_q <= 1'b0;
      vec_q     <= '0;
      vec_oe_q  <= 1'b0;
`ifdef AUTO_EOI_EN
      ack_live_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      irq_q     <= irq;
      inta_q    <= inta_n;
      irr_q     <= irr_d;
      imr_q     <= imr_d;
      isr_q     <= isr_d;
      lp_q      <= lp_d;
      idx_q     <= idx_d;
      int_out_q <= int_out_d;
      vec_q     <= vec_d;
      vec_oe_q  <= vec_oe_d;
`ifdef AUTO_EOI_EN
      ack_live_q <= ack_live_d;
`endif
    end
  end

  assign int_out    = int_out_q;
  assign vector_out = vec_q;
  assign vector_oe  = vec_oe_q;
  assign irr        = irr_q;
  assign imr        = imr_q;
  assign isr        = isr_q;

endmodule
